decoder_shifter_15: RTL and testbench
=====================================

// Module: decoder_shifter_15
// PURPOSE
//  Receive side of the serial Hamming link. Collects a serial Hamming(2^R-1, 2^R-1-R) codeword, default (15,11),
//  with optional SECDED overall-parity bit. Computes the syndrome, corrects single-bit errors and presents the
//  K data bits on a valid/ready output.
//  Sits after the serial channel, mirroring the encoder-side serial-in shifter.
// PARAMETERS
//  R         4  parity bits; N=2^R-1 codeword bits, K=N-R data bits (R in 3..5)
//  EXTENDED  0  1 = extra overall even-parity bit received last (SECDED)
// PORTS
//  clk              in   1    rising-edge clock, single domain
//  reset            in   1    asynchronous, active-low reset
//  clear            in   1    sync clear: drop partial word and pending output
//  in               in   1    serial codeword bit
//  shift            in   1    qualifies 'in'; one bit accepted per cycle shift=1
//  data_out         out  K    corrected data, d[0]=pos3 ... d[K-1]=pos N (non-power-of-2 positions, ascending)
//  syndrome         out  R    registered syndrome of the word in data_out
//  out_valid        out  1    data_out/flags valid
//  out_ready        in   1    consumer accepts when out_valid & out_ready
//  err_corrected    out  1    single error corrected (incl. overall-parity bit when EXTENDED)
//  err_uncorrectable out 1    EXTENDED only: double error detected, data_out uncorrected; tie 0 otherwise
//  overrun          out  1    1-cycle pulse: completed word dropped
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0, bit counter 0, state EMPTY. clear=1 gives the same result
//    synchronously and has priority over shift.
//  - Bit order: the first accepted bit is position 1 (cw[0]); the last is position N, then the parity bit
//    if EXTENDED. W = N+EXTENDED bits per word.
//  - Receive path: shift register plus counter 0..W-1. The counter always accepts shift and wraps to 0
//    after bit W-1. This is independent of the output state.
//  - Word complete (shift while count==W-1):
//      - If state EMPTY, or VALID with out_ready=1 that cycle: load {in, sreg} into hold reg cw_q, go to CHECK.
//      - Else (VALID, out_ready=0): word discarded, overrun=1 next cycle, outputs unchanged.
//  - Output FSM: EMPTY -> CHECK (word complete) -> VALID (always after 1 cycle).
//    - VALID -> EMPTY on out_ready, unless a word completes in the same cycle, then VALID -> CHECK.
//    - Latency: out_valid rises 2 edges after the edge that sampled the last bit.
//    - data_out, syndrome and flags are stable while out_valid=1.
//  - CHECK (combinational on cw_q, registered at CHECK->VALID):
//    - syn = XOR of position indices p (1..N) with cw_q[p-1]=1.
//    - pok = (XOR of all W bits)==0.
//  - Correction, EXTENDED=0:
//    - syn!=0: flip bit at position syn, err_corrected=1.
//  - Correction, EXTENDED=1:
//    - syn==0, pok: clean.
//    - syn!=0, !pok: flip position syn, err_corrected=1.
//    - syn==0, !pok: parity bit error, data clean, err_corrected=1.
//    - syn!=0, pok: err_uncorrectable=1, no flip.
//  - out_valid=0 implies flags are don't-care but held at their last value; overrun is independent of out_valid.
//  - reset mid-word or mid-VALID: the partial word and pending output are lost, and no overrun is raised.
// STRUCTURE
//  - hamming_pkg:
//    - functions n_of(R) and k_of(R).
//    - is_pow2(p).
//    - data_pos(i): position of data bit i.
//    - state enum {EMPTY, CHECK, VALID}.
//  - Sub-module hamming_syndrome_corr (combinational): cw -> syn, pok, corrected data.
//    The encoder bench model reuses it.
//  - Top: counter, sreg, cw_q, FSM, output registers.
// TESTING
//  1. Zero codeword, 15 shifts: data_out=11'h000, syndrome=0, no flags, out_valid 2 edges after last bit.
//  2. 15'h0010 (pos5 flipped): syndrome=5, data_out=11'h000, err_corrected=1.
//  3. 15'h7FFE (all-ones word, pos1 flipped): syndrome=1, data_out=11'h7FF, err_corrected=1.
//  4. EXTENDED=1, zero word with pos3+pos5 flipped and parity 0:
//     syndrome=6, err_uncorrectable=1, data_out=11'h003.
//  5. out_ready=0, two back-to-back words: second dropped, overrun pulses 1 cycle, first data held.
//     Then out_ready=1 while a third word completes: zero-bubble VALID->CHECK.
//  6. reset low after 7 shifts: outputs 0 immediately.
//     The next 15 shifts decode as a fresh word; clear mid-word behaves the same, synchronously.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming helpers: codeword geometry, data-bit placement and the receive FSM states.
// Pure compile-time functions; no logic is generated by this package on its own.
// Used by the serial decoder and its syndrome/correction core.
package hamming_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    CHECK = 2'd1,
    VALID = 2'd2
  } state_e;

  // Codeword length for R parity bits.
  function automatic int n_of(input int r);
    return (1 << r) - 1;
  endfunction

  // Data bits carried by a codeword with R parity bits.
  function automatic int k_of(input int r);
    return n_of(r) - r;
  endfunction

  // Powers of two are the parity positions.
  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Position (1-based) of data bit i: the i-th non-power-of-two position, ascending.
  function automatic int data_pos(input int i);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 1; p < 64; p++) begin
      if (!is_pow2(p)) begin
        if ((cnt == i) && (pos == 0)) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome_corr.sv
// Syndrome, overall-parity check and single-bit correction for one received codeword.
// Purely combinational, zero latency.
// No flow control; the caller holds the codeword stable while sampling the outputs.
module hamming_syndrome_corr
  import hamming_pkg::*;
#(
  parameter int R        = 4,
  parameter int EXTENDED = 0,
  localparam int N = n_of(R),
  localparam int K = k_of(R),
  localparam int W = N + EXTENDED
) (
  input  logic [W-1:0] i_cw,
  output logic [R-1:0] o_syn,
  output logic         o_pok,
  output logic [K-1:0] o_data,
  output logic         o_err_corrected,
  output logic         o_err_uncorrectable
);

  logic [R-1:0] w_syn;
  logic         w_pok;
  logic         w_flip;
  logic [N-1:0] w_fixed;

  // Syndrome: XOR of the indices of every set position.
  always_comb begin
    w_syn = '0;
    for (int p = 1; p <= N; p++) begin
      if (i_cw[p-1]) w_syn = w_syn ^ R'(p);
    end
  end

  // Overall parity covers every received bit, including the SECDED bit when present.
  assign w_pok = ~(^i_cw);

  // Flag decode: without the overall bit any non-zero syndrome is a single error;
  // with it, odd overall parity means one error and even parity with a syndrome means two.
  always_comb begin
    w_flip              = 1'b0;
    o_err_corrected     = 1'b0;
    o_err_uncorrectable = 1'b0;
    if (EXTENDED != 0) begin
      w_flip              = (w_syn != '0) && !w_pok;
      o_err_corrected     = !w_pok;
      o_err_uncorrectable = (w_syn != '0) && w_pok;
    end else begin
      w_flip          = (w_syn != '0);
      o_err_corrected = (w_syn != '0);
    end
  end

  // Flip the bit the syndrome points at, then pull the data bits out of their positions.
  always_comb begin
    w_fixed = i_cw[N-1:0];
    for (int p = 1; p <= N; p++) begin
      if (w_flip && (w_syn == R'(p))) w_fixed[p-1] = ~w_fixed[p-1];
    end
    o_data = '0;
    for (int i = 0; i < K; i++) begin
      o_data[i] = w_fixed[data_pos(i)-1];
    end
  end

  assign o_syn = w_syn;
  assign o_pok = w_pok;

endmodule

// File: rtl/decoder_shifter_15.sv
// Serial Hamming receiver: shifts in W bits per word, corrects single errors, presents K data bits.
// out_valid rises two edges after the edge that samples the last bit (one CHECK cycle in between).
// Shifting never stalls; a word completing while the output is held (VALID, !out_ready) is dropped with an overrun pulse.
module decoder_shifter_15
  import hamming_pkg::*;
#(
  parameter int R        = 4,
  parameter int EXTENDED = 0,
  localparam int N  = n_of(R),
  localparam int K  = k_of(R),
  localparam int W  = N + EXTENDED,
  localparam int CW = $clog2(W)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_in,
  input  logic         i_shift,
  output logic [K-1:0] o_data_out,
  output logic [R-1:0] o_syndrome,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic         o_err_corrected,
  output logic         o_err_uncorrectable,
  output logic         o_overrun
);

  logic [CW-1:0] r_cnt;
  logic [W-2:0]  r_sreg;
  logic [W-1:0]  r_cw;
  state_e        r_state;
  logic [K-1:0]  r_data;
  logic [R-1:0]  r_syn;
  logic          r_valid;
  logic          r_corr;
  logic          r_unc;
  logic          r_overrun;

  logic          w_last;
  logic          w_accept;
  logic [R-1:0]  w_syn;
  logic          w_pok;
  logic [K-1:0]  w_data;
  logic          w_corr;
  logic          w_unc;

  // The final bit of a word is being shifted in this cycle.
  assign w_last   = i_shift && (r_cnt == CW'(W - 1));
  // A completed word is kept if the output slot is free or is being drained this same cycle.
  assign w_accept = w_last && ((r_state == EMPTY) || ((r_state == VALID) && i_out_ready));

  // Receive shifter: first bit ends up in sreg[0]; counter wraps after the last bit regardless of output state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt  <= '0;
      r_sreg <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_sreg <= '0;
    end else if (i_shift) begin
      r_sreg <= {i_in, r_sreg[W-2:1]};
      r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // Hold register: snapshot of the complete codeword for the CHECK cycle.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cw <= '0;
    end else if (i_clear) begin
      r_cw <= '0;
    end else if (w_accept) begin
      r_cw <= {i_in, r_sreg};
    end
  end

  hamming_syndrome_corr #(
    .R        (R),
    .EXTENDED (EXTENDED)
  ) u_corr (
    .i_cw                (r_cw),
    .o_syn               (w_syn),
    .o_pok               (w_pok),
    .o_data              (w_data),
    .o_err_corrected     (w_corr),
    .o_err_uncorrectable (w_unc)
  );

  // Output FSM with registered outputs; results only change on CHECK->VALID so they stay put while held.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= EMPTY;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_syn     <= '0;
      r_corr    <= 1'b0;
      r_unc     <= 1'b0;
      r_overrun <= 1'b0;
    end else if (i_clear) begin
      r_state   <= EMPTY;
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_syn     <= '0;
      r_corr    <= 1'b0;
      r_unc     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_last && !w_accept;
      case (r_state)
        EMPTY: begin
          if (w_accept) r_state <= CHECK;
        end
        CHECK: begin
          r_state <= VALID;
          r_valid <= 1'b1;
          r_data  <= w_data;
          r_syn   <= w_syn;
          r_corr  <= w_corr;
          r_unc   <= w_unc;
        end
        VALID: begin
          if (w_accept) begin
            r_state <= CHECK;
            r_valid <= 1'b0;
          end else if (i_out_ready) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Overall-parity result only feeds the flag decode inside the core.
  logic w_unused_pok;
  assign w_unused_pok = w_pok;

  assign o_data_out          = r_data;
  assign o_syndrome          = r_syn;
  assign o_out_valid         = r_valid;
  assign o_err_corrected     = r_corr;
  assign o_err_uncorrectable = r_unc;
  assign o_overrun           = r_overrun;

endmodule

// File: tb/tb_decoder_shifter_15.sv
module tb_decoder_shifter_15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        inb  [2];
  logic        sh   [2];
  logic        rdy  [2];
  logic [10:0] dout [2];
  logic [3:0]  syn  [2];
  logic        vld  [2];
  logic        corr [2];
  logic        unc  [2];
  logic        ovr  [2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decoder_shifter_15 #(.R(4), .EXTENDED(0)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_clear(clr), .i_in(inb[0]), .i_shift(sh[0]),
    .o_data_out(dout[0]), .o_syndrome(syn[0]), .o_out_valid(vld[0]), .i_out_ready(rdy[0]),
    .o_err_corrected(corr[0]), .o_err_uncorrectable(unc[0]), .o_overrun(ovr[0])
  );

  decoder_shifter_15 #(.R(4), .EXTENDED(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_clear(clr), .i_in(inb[1]), .i_shift(sh[1]),
    .o_data_out(dout[1]), .o_syndrome(syn[1]), .o_out_valid(vld[1]), .i_out_ready(rdy[1]),
    .o_err_corrected(corr[1]), .o_err_uncorrectable(unc[1]), .o_overrun(ovr[1])
  );

  typedef struct {
    int          x;
    logic [15:0] cw;
    logic [10:0] d;
    logic [3:0]  s;
    logic        c;
    logic        u;
  } vec_t;

  vec_t tbl [7];

  // ---------------- reference model ----------------
  function automatic bit pw2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Build a valid codeword: data at non-power-of-two positions, parity bit 2^j covers positions with bit j set.
  function automatic logic [15:0] enc(input logic [10:0] d, input int x);
    logic [15:0] cw;
    int k;
    logic par;
    cw = '0;
    k  = 0;
    for (int p = 1; p <= 15; p++) begin
      if (!pw2(p)) begin
        cw[p-1] = d[k];
        k++;
      end
    end
    for (int j = 0; j < 4; j++) begin
      par = 1'b0;
      for (int p = 1; p <= 15; p++) begin
        if (((p >> j) & 1) == 1 && !pw2(p)) par = par ^ cw[p-1];
      end
      cw[(1 << j) - 1] = par;
    end
    if (x != 0) cw[15] = ^cw[14:0];
    return cw;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] cw);
    logic [10:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p <= 15; p++) begin
      if (!pw2(p)) begin
        d[k] = cw[p-1];
        k++;
      end
    end
    return d;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int x, input logic [15:0] cw, input bit gaps, input bit rdy_last);
    int w;
    w = (x != 0) ? 16 : 15;
    for (int i = 0; i < w; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        sh[x]  = 1'b0;
        inb[x] = 1'($urandom);
        tick();
      end
      inb[x] = cw[i];
      sh[x]  = 1'b1;
      if (i == w - 1) rdy[x] = rdy_last;
      tick();
    end
    sh[x]  = 1'b0;
    rdy[x] = 1'b0;
  endtask

  task automatic partial(input int x, input int n);
    for (int i = 0; i < n; i++) begin
      inb[x] = 1'($urandom);
      sh[x]  = 1'b1;
      tick();
    end
    sh[x] = 1'b0;
  endtask

  // Called right after send(): edges counted from the one that sampled the last bit.
  task automatic wait_valid(input int x, input string nm);
    int lat;
    lat = 1;
    while (!vld[x] && lat < 20) begin
      tick();
      lat++;
    end
    chk({nm, "_latency"}, lat, 2);
  endtask

  task automatic check_out(input int x, input string nm, input logic [10:0] d,
                           input logic [3:0] s, input logic c, input logic u);
    chk({nm, "_data"}, dout[x], d);
    chk({nm, "_syn"},  syn[x],  s);
    chk({nm, "_corr"}, corr[x], c);
    chk({nm, "_unc"},  unc[x],  u);
  endtask

  task automatic pop(input int x, input string nm);
    rdy[x] = 1'b1;
    tick();
    rdy[x] = 1'b0;
    chk({nm, "_pop_vld"}, vld[x], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b, c, dw, cw;
    logic [10:0] d;
    logic [3:0]  es;
    logic        ec, eu;
    int          x, ne, p1, p2;

    tbl[0] = '{0, 16'h0000, 11'h000, 4'd0, 1'b0, 1'b0};
    tbl[1] = '{0, 16'h0010, 11'h000, 4'd5, 1'b1, 1'b0};
    tbl[2] = '{0, 16'h7FFE, 11'h7FF, 4'd1, 1'b1, 1'b0};
    tbl[3] = '{1, 16'h0014, 11'h003, 4'd6, 1'b0, 1'b1};
    tbl[4] = '{1, 16'h8000, 11'h000, 4'd0, 1'b1, 1'b0};
    tbl[5] = '{1, 16'h0010, 11'h000, 4'd5, 1'b1, 1'b0};
    tbl[6] = '{1, 16'hFFFF, 11'h7FF, 4'd0, 1'b0, 1'b0};

    rst_n = 1'b0;
    clr   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inb[i] = 1'b0;
      sh[i]  = 1'b0;
      rdy[i] = 1'b0;
    end
    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("reset_vld", vld[i], 0);
      check_out(i, "reset", 11'h000, 4'd0, 1'b0, 1'b0);
      chk("reset_ovr", ovr[i], 0);
    end
    rst_n = 1'b1;
    tick();

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].x, tbl[i].cw, 1'b0, 1'b0);
      chk("tbl_vld_early", vld[tbl[i].x], 0);
      wait_valid(tbl[i].x, "tbl");
      check_out(tbl[i].x, "tbl", tbl[i].d, tbl[i].s, tbl[i].c, tbl[i].u);
      pop(tbl[i].x, "tbl");
    end

    // Overrun with out_ready low, then zero-bubble hand-over
    a = enc(11'h5A3, 0);
    b = enc(11'h1C4, 0) ^ 16'h0040;
    c = enc(11'h2B7, 0);
    send(0, a, 1'b0, 1'b0);
    wait_valid(0, "ovA");
    send(0, b, 1'b0, 1'b0);
    chk("ov_pulse", ovr[0], 1);
    chk("ov_hold_vld", vld[0], 1);
    chk("ov_hold_data", dout[0], 11'h5A3);
    tick();
    chk("ov_pulse_end", ovr[0], 0);
    chk("ov_hold_data2", dout[0], 11'h5A3);
    send(0, c, 1'b0, 1'b1);
    chk("zb_check_vld", vld[0], 0);
    chk("zb_no_ovr", ovr[0], 0);
    tick();
    chk("zb_vld", vld[0], 1);
    check_out(0, "zb", 11'h2B7, 4'd0, 1'b0, 1'b0);
    pop(0, "zb");

    // Async reset mid-word with a pending output
    dw = enc(11'h6E1, 0) ^ 16'h0100;
    send(0, a, 1'b0, 1'b0);
    wait_valid(0, "rsA");
    partial(0, 7);
    rst_n = 1'b0;
    #1;
    chk("rst_async_vld", vld[0], 0);
    chk("rst_async_data", dout[0], 0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("rst_no_ovr", ovr[0], 0);
    send(0, dw, 1'b0, 1'b0);
    wait_valid(0, "rst_fresh");
    check_out(0, "rst_fresh", 11'h6E1, 4'd9, 1'b1, 1'b0);
    pop(0, "rst_fresh");

    // Synchronous clear mid-word, asserted together with a shift
    send(0, a, 1'b0, 1'b0);
    wait_valid(0, "clA");
    partial(0, 7);
    clr    = 1'b1;
    sh[0]  = 1'b1;
    inb[0] = 1'b1;
    #1;
    chk("clr_sync_hold", vld[0], 1);
    tick();
    clr   = 1'b0;
    sh[0] = 1'b0;
    chk("clr_vld", vld[0], 0);
    chk("clr_data", dout[0], 0);
    chk("clr_no_ovr", ovr[0], 0);
    send(0, dw, 1'b0, 1'b0);
    wait_valid(0, "clr_fresh");
    check_out(0, "clr_fresh", 11'h6E1, 4'd9, 1'b1, 1'b0);
    pop(0, "clr_fresh");

    // Random words with injected errors, checked against the encoder model
    for (int it = 0; it < 60; it++) begin
      x  = it % 2;
      d  = 11'($urandom);
      cw = enc(d, x);
      es = 4'd0;
      ec = 1'b0;
      eu = 1'b0;
      if (x == 0) begin
        p1 = $urandom_range(0, 15);
        if (p1 != 0) begin
          cw[p1-1] = ~cw[p1-1];
          es = 4'(p1);
          ec = 1'b1;
        end
      end else begin
        ne = $urandom_range(0, 2);
        p1 = $urandom_range(1, 16);
        p2 = $urandom_range(1, 15);
        if (p2 >= p1) p2++;
        if (ne >= 1) cw[p1-1] = ~cw[p1-1];
        if (ne == 2) cw[p2-1] = ~cw[p2-1];
        if (ne == 1) begin
          es = 4'(p1 & 15);
          ec = 1'b1;
        end else if (ne == 2) begin
          es = 4'((p1 & 15) ^ (p2 & 15));
          eu = 1'b1;
          d  = extract(cw[14:0]);
        end
      end
      send(x, cw, 1'b1, 1'b0);
      wait_valid(x, "rnd");
      check_out(x, "rnd", d, es, ec, eu);
      pop(x, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
